// File: rtl/axis_rr_arbiter_if.sv
// Bundled handshake/data signals between NUM_SRC stream sources, the arbiter and one sink.
// The slave modport is the arbiter's view; master is the surrounding environment's view.
interface axis_rr_arbiter_if #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned AXIS_WIDTH = 32,
  parameter int unsigned ID_W       = $clog2(NUM_SRC)
) ();

  logic [NUM_SRC-1:0]            s_axis_tvalid;
  logic [NUM_SRC*AXIS_WIDTH-1:0] s_axis_tdata;
  logic [NUM_SRC-1:0]            s_axis_tready;
  logic                          m_axis_tvalid;
  logic [AXIS_WIDTH-1:0]         m_axis_tdata;
  logic [ID_W-1:0]               m_axis_tid;
  logic                          m_axis_tready;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tid
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tid
  );

endinterface

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter sharing one AXI-Stream sink among NUM_SRC sources, with bursts of up
// to MAX_BURST beats per grant and a fully registered output tagged with the source index.
module axis_rr_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned AXIS_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 4,
  parameter int unsigned ID_W       = $clog2(NUM_SRC)
) (
  input  logic                clk,
  input  logic                reset,
  axis_rr_arbiter_if.slave    bus,
  output logic                busy
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state;
  logic [ID_W-1:0]       gnt;
  logic [ID_W-1:0]       ptr;
  logic [CNT_W-1:0]      cnt;

  logic [ID_W-1:0]       pick_c;
  logic [ID_W-1:0]       gnt_next_c;
  logic [AXIS_WIDTH-1:0] src_data_c [NUM_SRC];
  logic                  out_free_c;
  logic                  accept_c;
  logic                  last_beat_c;
  logic                  release_c;

  // Modulo-NUM_SRC increment; NUM_SRC need not be a power of two.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return ID_W'(s);
  endfunction

  always_comb begin
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      src_data_c[i] = bus.s_axis_tdata[i*AXIS_WIDTH +: AXIS_WIDTH];
    end
  end

  // Scan from the far end so the requester closest to ptr is the last (winning) write.
  always_comb begin
    pick_c = ptr;
    for (int k = int'(NUM_SRC) - 1; k >= 0; k--) begin
      if (bus.s_axis_tvalid[wrap_add(ptr, unsigned'(k))]) pick_c = wrap_add(ptr, unsigned'(k));
    end
  end

  assign out_free_c  = !bus.m_axis_tvalid || bus.m_axis_tready;
  assign accept_c    = (state == GRANT) && out_free_c && bus.s_axis_tvalid[gnt];
  assign last_beat_c = (cnt + CNT_W'(1)) == CNT_W'(MAX_BURST);
  assign release_c   = (state == GRANT) &&
                       ((accept_c && last_beat_c) || !bus.s_axis_tvalid[gnt]);
  assign gnt_next_c  = wrap_add(gnt, 32'd1);

  assign bus.s_axis_tready = ((state == GRANT) && out_free_c) ? (NUM_SRC'(1) << gnt)
                                                               : '0;
  assign busy = (state == GRANT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      gnt               <= '0;
      ptr               <= '0;
      cnt               <= '0;
      bus.m_axis_tvalid <= 1'b0;
      bus.m_axis_tdata  <= '0;
      bus.m_axis_tid    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.s_axis_tvalid) begin
            gnt   <= pick_c;
            cnt   <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (accept_c) cnt <= cnt + CNT_W'(1);
          if (release_c) begin
            ptr   <= gnt_next_c;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Output register: a load wins over a simultaneous drain.
      if (accept_c) begin
        bus.m_axis_tvalid <= 1'b1;
        bus.m_axis_tdata  <= src_data_c[gnt];
        bus.m_axis_tid    <= gnt;
      end else if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        bus.m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: accepted source beats are queued with their
// expected tid and popped when the sink handshakes.
module tb_axis_rr_arbiter;

  localparam int unsigned NUM_SRC    = 4;
  localparam int unsigned AXIS_WIDTH = 32;
  localparam int unsigned MAX_BURST  = 4;
  localparam int unsigned ID_W       = 2;

  logic clk = 1'b0;
  logic reset;
  logic busy;

  always #5 clk = ~clk;

  axis_rr_arbiter_if #(.NUM_SRC(NUM_SRC), .AXIS_WIDTH(AXIS_WIDTH), .ID_W(ID_W)) ifc ();

  axis_rr_arbiter #(
    .NUM_SRC(NUM_SRC), .AXIS_WIDTH(AXIS_WIDTH), .MAX_BURST(MAX_BURST), .ID_W(ID_W)
  ) dut (
    .clk(clk), .reset(reset), .bus(ifc), .busy(busy)
  );

  int checks;
  int errors;
  int cyc;
  int delivered;
  logic [NUM_SRC-1:0]    src_valid;
  logic [NUM_SRC-1:0]    rdy_acc;
  logic [AXIS_WIDTH-1:0] base [NUM_SRC];
  int unsigned           seq [NUM_SRC];
  int                    acc_cnt [NUM_SRC];
  int unsigned           stride;
  logic                  busy_s;
  logic [ID_W+AXIS_WIDTH-1:0] sb [$];
  int tid_log [$];
  int out_cyc [$];

  function automatic logic [AXIS_WIDTH-1:0] src_word(input int i);
    return base[i] + AXIS_WIDTH'(seq[i] * stride);
  endfunction

  // One clock: drive sources, sample handshakes at the falling edge, step past the rising edge.
  task automatic cycle();
    logic [ID_W+AXIS_WIDTH-1:0] exp_v;
    for (int i = 0; i < int'(NUM_SRC); i++)
      ifc.s_axis_tdata[i*AXIS_WIDTH +: AXIS_WIDTH] = src_word(i);
    ifc.s_axis_tvalid = src_valid;
    @(negedge clk);
    busy_s  = busy;
    rdy_acc = rdy_acc | ifc.s_axis_tready;
    checks++;
    if ($countones(ifc.s_axis_tready) > 1) begin
      errors++;
      $display("FAIL ready_onehot: s_axis_tready=%b, required at most one bit", ifc.s_axis_tready);
    end
    if (!reset) begin
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (ifc.s_axis_tvalid[i] && ifc.s_axis_tready[i]) begin
          sb.push_back({ID_W'(i), src_word(i)});
          seq[i]++;
          acc_cnt[i]++;
        end
      end
      if (ifc.m_axis_tvalid && ifc.m_axis_tready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL out_beat: got tid=%0d data=%h, required no beat",
                   ifc.m_axis_tid, ifc.m_axis_tdata);
        end else begin
          exp_v = sb.pop_front();
          if ({ifc.m_axis_tid, ifc.m_axis_tdata} !== exp_v) begin
            errors++;
            $display("FAIL out_beat: got tid=%0d data=%h, required tid=%0d data=%h",
                     ifc.m_axis_tid, ifc.m_axis_tdata,
                     exp_v[ID_W+AXIS_WIDTH-1:AXIS_WIDTH], exp_v[AXIS_WIDTH-1:0]);
          end
        end
        tid_log.push_back(int'(ifc.m_axis_tid));
        out_cyc.push_back(cyc);
        delivered++;
      end
    end else begin
      sb.delete();
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src_valid = '0;
    ifc.m_axis_tready = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    sb.delete();
    tid_log.delete();
    out_cyc.delete();
    delivered = 0;
    rdy_acc = '0;
    stride = 1;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      seq[i] = 0;
      acc_cnt[i] = 0;
      base[i] = '0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    src_valid = '1;
    ifc.m_axis_tready = 1'b0;
    cycle();
    cycle();
    checks += 5;
    if (ifc.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b, required 0", ifc.m_axis_tvalid); end
    if (ifc.m_axis_tdata !== '0) begin errors++; $display("FAIL rst_tdata: got %h, required 0", ifc.m_axis_tdata); end
    if (ifc.m_axis_tid !== '0) begin errors++; $display("FAIL rst_tid: got %0d, required 0", ifc.m_axis_tid); end
    if (ifc.s_axis_tready !== '0) begin errors++; $display("FAIL rst_sready: got %b, required 0", ifc.s_axis_tready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    do_reset();
  endtask

  task automatic test_single_source();
    do_reset();
    base[0] = 32'h10;
    src_valid = 4'b0001;
    for (int k = 0; k < 60 && delivered < 8; k++) cycle();
    checks++;
    if (delivered < 8) begin
      errors++;
      $display("FAIL single_timeout: got %0d beats, required 8", delivered);
    end else begin
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (out_cyc[k+1] - out_cyc[k] != ((k == 3) ? 2 : 1)) begin
          errors++;
          $display("FAIL single_gap%0d: got %0d cycles, required %0d",
                   k, out_cyc[k+1] - out_cyc[k], (k == 3) ? 2 : 1);
        end
      end
    end
    src_valid = '0;
    for (int k = 0; k < 4; k++) cycle();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL single_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_all_sources();
    int low_run;
    int runs;
    logic seen;
    do_reset();
    for (int i = 0; i < int'(NUM_SRC); i++) base[i] = AXIS_WIDTH'(32'hA0 + i);
    stride = 32'h100;
    src_valid = '1;
    low_run = 0;
    runs = 0;
    seen = 1'b0;
    for (int k = 0; k < 200 && delivered < 20; k++) begin
      cycle();
      if (busy_s) seen = 1'b1;
      if (seen) begin
        if (!busy_s) low_run++;
        else if (low_run > 0) begin
          checks++;
          if (low_run != 1) begin errors++; $display("FAIL all_gap: got %0d idle cycles, required 1", low_run); end
          runs++;
          low_run = 0;
        end
      end
    end
    checks++;
    if (delivered < 20) begin
      errors++;
      $display("FAIL all_timeout: got %0d beats, required 20", delivered);
    end else begin
      for (int k = 0; k < 20; k++) begin
        checks++;
        if (tid_log[k] != (k / 4) % 4) begin
          errors++;
          $display("FAIL all_order%0d: got tid %0d, required %0d", k, tid_log[k], (k / 4) % 4);
        end
      end
    end
    checks++;
    if (runs != 4) begin errors++; $display("FAIL all_runs: got %0d idle gaps, required 4", runs); end
    src_valid = '0;
    for (int k = 0; k < 6; k++) cycle();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL all_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_skip();
    int exp_tid [12] = '{1, 1, 1, 1, 3, 3, 3, 3, 1, 1, 1, 1};
    do_reset();
    base[1] = 32'h1000;
    base[3] = 32'h3000;
    src_valid = 4'b1010;
    for (int k = 0; k < 100 && delivered < 12; k++) cycle();
    checks++;
    if (delivered < 12) begin
      errors++;
      $display("FAIL skip_timeout: got %0d beats, required 12", delivered);
    end else begin
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (tid_log[k] != exp_tid[k]) begin
          errors++;
          $display("FAIL skip_order%0d: got tid %0d, required %0d", k, tid_log[k], exp_tid[k]);
        end
      end
    end
    checks++;
    if (rdy_acc !== 4'b1010) begin errors++; $display("FAIL skip_ready: got ready union %b, required 1010", rdy_acc); end
    src_valid = '0;
    for (int k = 0; k < 6; k++) cycle();
  endtask

  task automatic test_stall();
    do_reset();
    base[0] = 32'h40;
    src_valid = 4'b0001;
    for (int k = 0; k < 30 && delivered < 2; k++) cycle();
    ifc.m_axis_tready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      cycle();
      checks++;
      if (sb.size() == 0 || ifc.m_axis_tvalid !== 1'b1 ||
          {ifc.m_axis_tid, ifc.m_axis_tdata} !== sb[0]) begin
        errors++;
        $display("FAIL stall_hold%0d: got valid=%b tid=%0d data=%h, required held front of %0d queued",
                 s, ifc.m_axis_tvalid, ifc.m_axis_tid, ifc.m_axis_tdata, sb.size());
      end
      checks++;
      if (ifc.s_axis_tready !== '0) begin
        errors++;
        $display("FAIL stall_ready%0d: got %b, required 0000", s, ifc.s_axis_tready);
      end
    end
    ifc.m_axis_tready = 1'b1;
    for (int k = 0; k < 40 && delivered < 6; k++) cycle();
    checks++;
    if (delivered < 6) begin
      errors++;
      $display("FAIL stall_timeout: got %0d beats, required 6", delivered);
    end else if (out_cyc[4] - out_cyc[3] != 2) begin
      errors++;
      $display("FAIL stall_burst: got gap %0d after 4th beat, required 2", out_cyc[4] - out_cyc[3]);
    end
    src_valid = '0;
    for (int k = 0; k < 6; k++) cycle();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL stall_drain: got %0d pending, required 0", sb.size()); end
  endtask

  task automatic test_drop();
    do_reset();
    base[0] = 32'h7000;
    base[2] = 32'h200;
    base[3] = 32'h9000;
    src_valid = 4'b0100;
    for (int k = 0; k < 20 && acc_cnt[2] < 2; k++) cycle();
    src_valid = '0;
    cycle();
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL drop_release: got busy=%b, required 0", busy); end
    if (acc_cnt[2] != 2) begin errors++; $display("FAIL drop_count: got %0d accepted, required 2", acc_cnt[2]); end
    src_valid = 4'b1001;
    for (int k = 0; k < 30 && delivered < 3; k++) cycle();
    checks++;
    if (delivered < 3) begin
      errors++;
      $display("FAIL drop_timeout: got %0d beats, required 3", delivered);
    end else if (tid_log[0] != 2 || tid_log[1] != 2 || tid_log[2] != 3) begin
      errors++;
      $display("FAIL drop_order: got tids %0d,%0d,%0d, required 2,2,3", tid_log[0], tid_log[1], tid_log[2]);
    end
    src_valid = '0;
    for (int k = 0; k < 8; k++) cycle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    base[1] = 32'h300;
    base[3] = 32'h500;
    src_valid = 4'b1010;
    for (int k = 0; k < 30 && delivered < 4; k++) cycle();
    ifc.m_axis_tready = 1'b0;
    cycle();
    cycle();
    checks++;
    if (ifc.m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL rmid_full: got tvalid=%b, required 1", ifc.m_axis_tvalid); end
    reset = 1'b1;
    cycle();
    checks += 3;
    if (ifc.m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rmid_tvalid: got %b, required 0", ifc.m_axis_tvalid); end
    if (ifc.s_axis_tready !== '0) begin errors++; $display("FAIL rmid_sready: got %b, required 0", ifc.s_axis_tready); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b, required 0", busy); end
    reset = 1'b0;
    ifc.m_axis_tready = 1'b1;
    tid_log.delete();
    for (int k = 0; k < 20 && tid_log.size() < 1; k++) cycle();
    checks++;
    if (tid_log.size() < 1) begin
      errors++;
      $display("FAIL rmid_timeout: got no beat, required tid 1");
    end else if (tid_log[0] != 1) begin
      errors++;
      $display("FAIL rmid_first: got tid %0d, required 1", tid_log[0]);
    end
    src_valid = '0;
    for (int k = 0; k < 8; k++) cycle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc = 0;
    delivered = 0;
    reset = 1'b1;
    src_valid = '0;
    rdy_acc = '0;
    stride = 1;
    ifc.m_axis_tready = 1'b1;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      base[i] = '0;
      seq[i] = 0;
      acc_cnt[i] = 0;
    end
    test_reset();
    test_single_source();
    test_all_sources();
    test_skip();
    test_stall();
    test_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
